pipe_mux_skid: RTL and testbench
================================

// Module: pipe_mux_skid
// PURPOSE
//   N-way, WIDTH-bit parametrised operand selector with a registered output.
//   Replaces the fixed 2/3-input combinational muxes at pipeline-stage boundaries.
//   The output is a 2-entry skid buffer with a valid/ready handshake, so a stage
//   can stall without a combinational ready path, and a flush drops buffered beats.
// PARAMETERS
//   WIDTH  32  data bits per input and on the output
//   N      4   number of selectable inputs, N >= 2
//   SEL_W  2   select width; must satisfy 2**SEL_W >= N
// PORTS
//   clk          in   1        rising-edge clock
//   rst          in   1        synchronous, active-high reset
//   flush        in   1        drop all buffered beats; wins over every other event
//   sel          in   SEL_W    input index, sampled with the beat
//   in_data      in   N*WIDTH  flattened inputs; input k = in_data[k*WIDTH +: WIDTH]
//   in_valid     in   1        producer has a beat
//   in_ready     out  1        block accepts a beat this cycle
//   out_data     out  WIDTH    head-of-buffer data
//   out_sel_err  out  1        head beat was captured with sel >= N
//   out_valid    out  1        head-of-buffer valid
//   out_ready    in   1        consumer takes the head this cycle
// BEHAVIOUR
//   - Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
//     After reset: state EMPTY, out_valid=0, out_data=0, out_sel_err=0.
//     in_ready=0 in every cycle in which rst=1.
//   - Select: selected word = input[sel] when sel < N. When sel >= N, the word is 0
//     and its err bit is 1. The err bit travels with the word through both entries.
//   - Handshakes:
//     - accept = in_valid & in_ready; pop = out_valid & out_ready.
//     - in_ready = !rst & !flush & (state != TWO). This is the only
//       combinational input-to-output path (flush/rst).
//   - States. MAIN and SKID are WIDTH+1-bit registers.
//     - EMPTY: out_valid=0. On accept: MAIN <= selected, go to ONE.
//     - ONE: out_valid=1, output = MAIN.
//       - accept and no pop: SKID <= selected, go to TWO.
//       - accept and pop: MAIN <= selected, stay in ONE.
//       - pop only: go to EMPTY.
//       - neither: hold.
//     - TWO: out_valid=1, output = MAIN, in_ready=0.
//       - pop: MAIN <= SKID, go to ONE.
//       - otherwise hold.
//   - Latency: accept in EMPTY gives out_valid=1 on the next cycle (1 cycle).
//     Throughput is 1 beat/cycle while out_ready=1.
//   - Ordering: strict FIFO order. No beat is dropped or duplicated except on flush.
//   - Stability: while out_valid & !out_ready, out_data and out_sel_err hold their
//     values until pop, flush or rst.
//   - Flush: the next state is EMPTY. A beat presented in the flush cycle is not
//     accepted (in_ready=0). A pop in the flush cycle is still a completed transfer.
//     Data registers may keep stale contents; out_data is don't-care while out_valid=0.
//   - Simultaneous events:
//     - rst overrides flush, and flush overrides accept/pop state updates.
//     - Reset mid-transfer discards both entries.
// TESTING
//   1. Reset, N=4, WIDTH=32, in_data={D3..D0}, sel=2, single accept, out_ready=1
//      -> in_ready=1; next cycle out_valid=1, out_data=D2, out_sel_err=0;
//      the cycle after, out_valid=0.
//   2. N=3, SEL_W=2, sel=3 beat accepted -> out_data=0, out_sel_err=1.
//   3. out_ready=0, three beats with sel=0,1,2 -> beats 0 and 1 are accepted;
//      in_ready=0 once in TWO; beat 2 is held by the producer. Release out_ready
//      -> output order D0, D1, D2, with no gaps once streaming.
//   4. Continuous in_valid=1/out_ready=1 for 16 beats with sel=i%4 -> 16 outputs,
//      1 per cycle, in order; state never leaves ONE after the first beat.
//   5. State TWO with flush=1 and in_valid=1 -> in_ready=0; next cycle
//      out_valid=0, state EMPTY; the following beat emerges with 1-cycle latency.
//   6. State TWO with rst=1 -> next cycle out_valid=0, out_data=0,
//      out_sel_err=0; in_ready=0 during rst and 1 after rst falls.

Source files
------------

// File: rtl/pipe_mux_skid.sv
// pipe_mux_skid: N-way operand selector feeding a 2-entry skid buffer.
// The output side is fully registered; the only combinational path from
// inputs to outputs is rst/flush into in_ready.
module pipe_mux_skid #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SEL_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [SEL_W-1:0]   sel,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_sel_err,
   output logic               out_valid,
   input  logic               out_ready
);

   // A buffered beat: the selected word plus the out-of-range flag.
   typedef struct packed {
      logic             err;
      logic [WIDTH-1:0] data;
   } beat_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t state_q, state_d;
   beat_t  main_q, main_d;
   beat_t  skid_q, skid_d;
   beat_t  sel_beat;
   logic   accept, pop;

   // Operand select: an index with no matching input yields a zero word with err set.
   always_comb begin
      sel_beat      = '0;
      sel_beat.err  = 1'b1;
      for (int k = 0; k < N; k++) begin
         if (sel == SEL_W'(k)) begin
            sel_beat.data = in_data[k*WIDTH +: WIDTH];
            sel_beat.err  = 1'b0;
         end
      end
   end

   assign in_ready    = !rst && !flush && (state_q != S_TWO);
   assign out_valid   = (state_q != S_EMPTY);
   assign out_data    = main_q.data;
   assign out_sel_err = main_q.err;
   assign accept      = in_valid && in_ready;
   assign pop         = out_valid && out_ready;

   // Next-state and data-register updates; flush empties the buffer without touching data.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  main_d  = sel_beat;
                  state_d = S_ONE;
               end
            end
            S_ONE: begin
               if (accept && !pop) begin
                  skid_d  = sel_beat;
                  state_d = S_TWO;
               end else if (accept && pop) begin
                  main_d  = sel_beat;
               end else if (pop) begin
                  state_d = S_EMPTY;
               end
            end
            S_TWO: begin
               if (pop) begin
                  main_d  = skid_q;
                  state_d = S_ONE;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
   end

   // State and entry registers; reset clears both entries so out_data reads zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_pipe_mux_skid.sv
// Directed bench for pipe_mux_skid: a 4-input instance for the main scenarios
// and a 3-input instance for the out-of-range select case.
module tb_pipe_mux_skid;

   localparam logic [31:0] D0 = 32'h1111_0000;
   localparam logic [31:0] D1 = 32'h2222_0001;
   localparam logic [31:0] D2 = 32'h3333_0002;
   localparam logic [31:0] D3 = 32'h4444_0003;

   logic         clk = 1'b0;
   logic         rst, flush, in_valid, out_ready;
   logic [1:0]   sel;
   logic [127:0] in_data;
   logic         in_ready, out_sel_err, out_valid;
   logic [31:0]  out_data;

   logic         flush3, in_valid3, out_ready3;
   logic [1:0]   sel3;
   logic [95:0]  in_data3;
   logic         in_ready3, out_sel_err3, out_valid3;
   logic [31:0]  out_data3;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   pipe_mux_skid #(.WIDTH(32), .N(4), .SEL_W(2)) u_dut4 (
      .clk(clk), .rst(rst), .flush(flush), .sel(sel), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
      .out_sel_err(out_sel_err), .out_valid(out_valid), .out_ready(out_ready)
   );

   pipe_mux_skid #(.WIDTH(32), .N(3), .SEL_W(2)) u_dut3 (
      .clk(clk), .rst(rst), .flush(flush3), .sel(sel3), .in_data(in_data3),
      .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
      .out_sel_err(out_sel_err3), .out_valid(out_valid3), .out_ready(out_ready3)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 2'd0;
      in_data = {D3, D2, D1, D0};
      flush3 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0; sel3 = 2'd0;
      in_data3 = {D2, D1, D0};
      tick(); tick();

      // Reset state
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_err", 64'(out_sel_err), 64'd0);
      rst = 1'b0;
      #1;

      // 1: single beat, sel=2, 1-cycle latency
      in_valid = 1'b1; sel = 2'd2; out_ready = 1'b1;
      #1 chk("t1_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_data", 64'(out_data), 64'(D2));
      chk("t1_err", 64'(out_sel_err), 64'd0);
      tick();
      chk("t1_drain", 64'(out_valid), 64'd0);

      // 2: N=3 instance, sel=3 is out of range, then an in-range beat
      in_valid3 = 1'b1; sel3 = 2'd3; out_ready3 = 1'b1;
      #1 chk("t2_in_ready", 64'(in_ready3), 64'd1);
      tick();
      sel3 = 2'd1;
      chk("t2_valid", 64'(out_valid3), 64'd1);
      chk("t2_data0", 64'(out_data3), 64'd0);
      chk("t2_err1", 64'(out_sel_err3), 64'd1);
      tick();
      in_valid3 = 1'b0;
      chk("t2_data_d1", 64'(out_data3), 64'(D1));
      chk("t2_err0", 64'(out_sel_err3), 64'd0);
      tick();
      chk("t2_drain", 64'(out_valid3), 64'd0);

      // 3: stall fills both entries, third beat held, then ordered drain
      out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
      #1 chk("t3_rdy_b0", 64'(in_ready), 64'd1);
      tick();
      sel = 2'd1;
      chk("t3_head_d0", 64'(out_data), 64'(D0));
      chk("t3_rdy_b1", 64'(in_ready), 64'd1);
      tick();
      sel = 2'd2;
      #1 chk("t3_rdy_two", 64'(in_ready), 64'd0);
      tick();
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_d0", 64'(out_data), 64'(D0));
      out_ready = 1'b1;
      #1 chk("t3_rdy_still0", 64'(in_ready), 64'd0);
      tick();
      chk("t3_out_d1", 64'(out_data), 64'(D1));
      chk("t3_rdy_one", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      chk("t3_out_d2_v", 64'(out_valid), 64'd1);
      chk("t3_out_d2", 64'(out_data), 64'(D2));
      tick();
      chk("t3_drain", 64'(out_valid), 64'd0);

      // 4: 16 streaming beats, one per cycle, word k of beat i = {i, k}
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         sel = 2'(i % 4);
         for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = {16'(i), 16'(k)};
         #1 chk($sformatf("t4_rdy_%0d", i), 64'(in_ready), 64'd1);
         tick();
         chk($sformatf("t4_valid_%0d", i), 64'(out_valid), 64'd1);
         chk($sformatf("t4_data_%0d", i), 64'(out_data), 64'({16'(i), 16'(i % 4)}));
      end
      in_valid = 1'b0;
      in_data = {D3, D2, D1, D0};
      tick();
      chk("t4_drain", 64'(out_valid), 64'd0);

      // 5: flush from TWO with a beat offered
      out_ready = 1'b0; in_valid = 1'b1; sel = 2'd3;
      tick();
      sel = 2'd1;
      tick();
      flush = 1'b1; sel = 2'd2;
      #1 chk("t5_rdy_flush", 64'(in_ready), 64'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("t5_empty", 64'(out_valid), 64'd0);
      in_valid = 1'b1; sel = 2'd0; out_ready = 1'b1;
      #1 chk("t5_rdy_after", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      chk("t5_valid", 64'(out_valid), 64'd1);
      chk("t5_data", 64'(out_data), 64'(D0));
      tick();
      chk("t5_drain", 64'(out_valid), 64'd0);

      // 6: reset while in TWO
      out_ready = 1'b0; in_valid = 1'b1; sel = 2'd3;
      tick();
      tick();
      in_valid = 1'b0;
      #1 chk("t6_rdy_two", 64'(in_ready), 64'd0);
      chk("t6_head_d3", 64'(out_data), 64'(D3));
      rst = 1'b1;
      #1 chk("t6_rdy_rst", 64'(in_ready), 64'd0);
      tick();
      chk("t6_valid", 64'(out_valid), 64'd0);
      chk("t6_data", 64'(out_data), 64'd0);
      chk("t6_err", 64'(out_sel_err), 64'd0);
      chk("t6_rdy_in_rst", 64'(in_ready), 64'd0);
      rst = 1'b0;
      #1 chk("t6_rdy_after", 64'(in_ready), 64'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
